// File: rtl/booth_pp_gen_pipe.sv
`default_nettype none
// ============================================================================
// booth_pp_gen_pipe: two-stage radix-4 Booth partial-product generator with
// valid/ready handshake. Optional zero_rows output via BOOTH_PP_ZERO_FLAG_EN.
// Revision: 1.0
// ============================================================================
module booth_pp_gen_pipe #(
   parameter int Bitwidth = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [Bitwidth-1:0]   a,
   input  logic [Bitwidth-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*Bitwidth-1:0] pp [0:Bitwidth/2-1]
`ifdef BOOTH_PP_ZERO_FLAG_EN
   ,
   output logic [Bitwidth/2-1:0] zero_rows
`endif
);

   localparam int NDIG = Bitwidth / 2;
   localparam int PW   = 2 * Bitwidth;

   logic                s1_valid_q, s1_valid_d;
   logic [Bitwidth-1:0] a_q, a_d;
   logic [NDIG-1:0]     neg_q, neg_d, one_q, one_d, two_q, two_d;
   logic [NDIG-1:0]     enc_neg, enc_one, enc_two;
   logic                out_valid_q, out_valid_d;
   logic [PW-1:0]       pp_q [0:NDIG-1];
   logic [PW-1:0]       pp_d [0:NDIG-1];
   logic [Bitwidth:0]   b_ext;
   logic [PW-1:0]       a_ext, mag;
   logic                s2_adv, in_fire;

   always_comb begin
      s2_adv      = s1_valid_q & (~out_valid_q | out_ready);
      in_ready    = ~s1_valid_q | s2_adv;
      in_fire     = in_valid & in_ready;
      s1_valid_d  = in_fire | (s1_valid_q & ~s2_adv);
      out_valid_d = s2_adv | (out_valid_q & ~out_ready);
   end

   // Digit k looks at b[2k+1], b[2k], b[2k-1]; b_ext supplies the b[-1]=0 bit.
   always_comb begin
      b_ext   = {b, 1'b0};
      enc_neg = '0;
      enc_one = '0;
      enc_two = '0;
      for (int k = 0; k < NDIG; k++) begin
         enc_one[k] = b_ext[2*k+1] ^ b_ext[2*k];
         enc_two[k] = (b_ext[2*k+2] & ~b_ext[2*k+1] & ~b_ext[2*k]) |
                      (~b_ext[2*k+2] & b_ext[2*k+1] & b_ext[2*k]);
         enc_neg[k] = b_ext[2*k+2] & ~(b_ext[2*k+1] & b_ext[2*k]);
      end
      a_d   = in_fire ? a       : a_q;
      neg_d = in_fire ? enc_neg : neg_q;
      one_d = in_fire ? enc_one : one_q;
      two_d = in_fire ? enc_two : two_q;
   end

   always_comb begin
      a_ext = {{Bitwidth{a_q[Bitwidth-1]}}, a_q};
      mag   = '0;
      for (int k = 0; k < NDIG; k++) begin
         mag = one_q[k] ? a_ext : (two_q[k] ? (a_ext << 1) : '0);
         mag = neg_q[k] ? (~mag + PW'(1)) : mag;
         pp_d[k] = s2_adv ? (mag << (2*k)) : pp_q[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         neg_q       <= '0;
         one_q       <= '0;
         two_q       <= '0;
         out_valid_q <= 1'b0;
         for (int k = 0; k < NDIG; k++) pp_q[k] <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         neg_q       <= neg_d;
         one_q       <= one_d;
         two_q       <= two_d;
         out_valid_q <= out_valid_d;
         for (int k = 0; k < NDIG; k++) pp_q[k] <= pp_d[k];
      end
   end

   assign out_valid = out_valid_q;
   assign pp        = pp_q;

`ifdef BOOTH_PP_ZERO_FLAG_EN
   logic [NDIG-1:0] zero_rows_q, zero_rows_d;

   always_comb begin
      zero_rows_d = s2_adv ? ~(one_q | two_q) : zero_rows_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) zero_rows_q <= '1;
      else     zero_rows_q <= zero_rows_d;
   end

   assign zero_rows = zero_rows_q;
`else
   // Zero-digit flags are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_gen_pipe.sv
`default_nettype none
// tb_booth_pp_gen_pipe: scoreboard bench; expected rows queued at issue, monitor pops on output transfer.
module tb_booth_pp_gen_pipe;

   typedef struct packed {
      logic [7:0][31:0] row;
      logic [31:0]      prod;
      logic [7:0]       zr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pp [0:7];
`ifdef BOOTH_PP_ZERO_FLAG_EN
   logic [7:0]  zero_rows;
`endif

   logic        ready_mode  = 1'b0;
   logic        ready_force = 1'b1;
   logic        rnd_ready   = 1'b1;
   int          checks = 0;
   int          fails  = 0;
   int          cyc    = 0;
   exp_t        exp_q [$];

   booth_pp_gen_pipe #(.Bitwidth(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pp        (pp)
`ifdef BOOTH_PP_ZERO_FLAG_EN
      ,
      .zero_rows (zero_rows)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 99) < 70);
   end
   assign out_ready = ready_mode ? rnd_ready : ready_force;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
      end
   endtask

   // Reference straight from the digit formula: d = -2*b[2k+1] + b[2k] + b[2k-1].
   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
      exp_t        e;
      int          d;
      longint      r;
      longint      p;
      logic [16:0] bx;
      e  = '0;
      bx = {bv, 1'b0};
      p  = longint'($signed(av)) * longint'($signed(bv));
      e.prod = p[31:0];
      for (int k = 0; k < 8; k++) begin
         d = -2 * int'(bx[2*k+2]) + int'(bx[2*k+1]) + int'(bx[2*k]);
         r = longint'(d) * longint'($signed(av));
         r = r <<< (2*k);
         e.row[k] = r[31:0];
         e.zr[k]  = (d == 0);
      end
      return e;
   endfunction

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input exp_t e);
      int n;
      n = 0;
      in_valid = 1'b1;
      a = av;
      b = bv;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            break;
         end
         n++;
         if (n > 500) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: pops on every output transfer and checks stability under backpressure.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_pp [0:7];
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] s;
      logic        rows_ok;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            rows_ok = 1'b1;
            for (int k = 0; k < 8; k++) if (pp[k] != prev_pp[k]) rows_ok = 1'b0;
            chk("hold_pp", rows_ok, 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               s = '0;
               rows_ok = 1'b1;
               for (int k = 0; k < 8; k++) begin
                  s = s + pp[k];
                  if (pp[k] != e.row[k]) begin
                     rows_ok = 1'b0;
                     $display("  row %0d actual=0x%08h required=0x%08h", k, pp[k], e.row[k]);
                  end
               end
               chk("rows", rows_ok, 1);
               chk("row_sum", s, e.prod);
`ifdef BOOTH_PP_ZERO_FLAG_EN
               chk("zero_rows", zero_rows, e.zr);
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         for (int k = 0; k < 8; k++) prev_pp[k] = pp[k];
      end
   end

   initial begin
      #50_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        e;
      logic [31:0] orv;
      int          acc, idx, c0;
      logic [15:0] bp_a [0:4];
      logic [15:0] bp_b [0:4];
      logic [15:0] av, bv;
      bp_a = '{16'h0001, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFE};
      bp_b = '{16'h0002, 16'h7FFF, 16'h0003, 16'hABCD, 16'h8001};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      orv = '0;
      for (int k = 0; k < 8; k++) orv = orv | pp[k];
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pp_zero", orv, 0);
`ifdef BOOTH_PP_ZERO_FLAG_EN
      chk("rst_zero_rows", zero_rows, 8'hFF);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // a=3, b=5 with latency check
      e = '0;
      e.row[0] = 32'h0000_0003; e.row[1] = 32'h0000_000C;
      e.prod = 32'h0000_000F; e.zr = 8'hFC;
      send(16'd3, 16'd5, e);
      chk("lat_t1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_t2_valid", out_valid, 1);
      drain();

      e = '0;
      e.row[7] = 32'h0000_8000; e.prod = 32'h0000_8000; e.zr = 8'h7F;
      send(16'hFFFF, 16'h8000, e);
      e = '0;
      e.row[7] = 32'h4000_0000; e.prod = 32'h4000_0000; e.zr = 8'h7F;
      send(16'h8000, 16'h8000, e);
      e = '0;
      e.row[0] = 32'hFFFF_EDCC; e.prod = 32'hFFFF_EDCC; e.zr = 8'hFE;
      send(16'h1234, 16'hFFFF, e);
      e = '0;
      e.row[0] = 32'hFFFF_FFF2; e.row[1] = 32'h0000_001C;
      e.prod = 32'h0000_000E; e.zr = 8'hFC;
      send(16'd7, 16'd2, e);
      drain();

      // Back-to-back throughput
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(16'(i * 37 + 1), 16'(16'hF00F - i * 911), model(16'(i * 37 + 1), 16'(16'hF00F - i * 911)));
      chk("throughput_cycles", cyc - c0, 8);
      drain();

      // Backpressure: out_ready low, in_valid held for 5 cycles
      ready_force = 1'b0;
      acc = 0;
      idx = 0;
      in_valid = 1'b1;
      a = bp_a[0];
      b = bp_b[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(bp_a[idx], bp_b[idx]));
            acc++;
            idx++;
         end
         @(posedge clk);
         #1;
         if (idx < 5) begin
            a = bp_a[idx];
            b = bp_b[idx];
         end
      end
      @(negedge clk);
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ready_force = 1'b1;
      #1;
      chk("passthru_in_ready", in_ready, 1);
      drain();

      // Reset with two transactions in flight
      ready_force = 1'b0;
      send(16'h0011, 16'h0022, model(16'h0011, 16'h0022));
      send(16'h0033, 16'h0044, model(16'h0033, 16'h0044));
      chk("rst_pre_valid", out_valid, 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      orv = '0;
      for (int k = 0; k < 8; k++) orv = orv | pp[k];
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_pp_zero", orv, 0);
      chk("midrst_in_ready", in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      #2;
      rst = 1'b0;
      ready_force = 1'b1;
      @(posedge clk);
      #1;
      e = '0;
      e.row[0] = 32'h0000_0005; e.row[1] = 32'hFFFF_FFEC;
      e.prod = 32'hFFFF_FFF1; e.zr = 8'hFC;
      send(16'h0005, 16'hFFFD, e);
      drain();

      // Random operands with random valid/ready
      ready_mode = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         av = 16'($urandom);
         bv = 16'($urandom);
         if ($urandom_range(0, 15) == 0) av = 16'h8000;
         if ($urandom_range(0, 15) == 0) bv = 16'h8000;
         send(av, bv, model(av, bv));
      end
      ready_mode = 1'b0;
      ready_force = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
